// File: rtl/note_sequencer_pkg.sv
// note_seq_pkg: shared word layout, FSM state codes and note constants for the note sequencer
package note_seq_pkg;
  localparam int DEF_IDX_W = 6;
  localparam int DEF_NOTE_W = 4;
  localparam int DEF_DUR_W = 4;
  localparam int WORD_W = 1 + DEF_NOTE_W + DEF_DUR_W;
  localparam int LAST_BIT = DEF_NOTE_W + DEF_DUR_W;
  localparam int NOTE_LSB = DEF_DUR_W;
  localparam int DUR_LSB = 0;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_PLAY = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [DEF_NOTE_W-1:0] NOTE_REST = '0;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, song-memory and tone-output signals of the note sequencer
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W = DEF_DUR_W
);
  logic [1:0] select;
  logic start;
  logic enable;
  logic tick;
  logic [IDX_W+1:0] mem_addr;
  logic [NOTE_W+DUR_W:0] mem_rdata;
  logic [NOTE_W-1:0] note_out;
  logic note_valid;
  logic song_done;
  modport master (
    output select, start, enable, tick, mem_rdata,
    input mem_addr, note_out, note_valid, song_done
  );
  modport slave (
    input select, start, enable, tick, mem_rdata,
    output mem_addr, note_out, note_valid, song_done
  );
endinterface

// File: rtl/note_sequencer_duration_counter.sv
// duration_counter: loadable down-counter; zero_o flags the decrement that brings the count to zero
module duration_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign zero_o = dec_i && cnt_q == W'(1);
  // count register: load wins over decrement, never underflows
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks the selected song in memory, holding each note for its duration in tempo ticks
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DUR_W = DEF_DUR_W,
  parameter bit LOOP = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  note_sequencer_if.slave bus
);
  logic [2:0] state_q, state_d;
  logic [1:0] song_q, song_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic last_q, last_d;
  logic w_last;
  logic [NOTE_W-1:0] w_note;
  logic [DUR_W-1:0] w_dur;
  logic step, note_end;
  assign {w_last, w_note, w_dur} = bus.mem_rdata;
  assign step = state_q == S_PLAY && bus.tick && bus.enable;
  assign bus.mem_addr = {song_q, idx_q};
  assign bus.note_out = note_q;
  assign bus.note_valid = state_q == S_PLAY && bus.enable && note_q != NOTE_REST;
  assign bus.song_done = state_q == S_DONE && !bus.start;
  duration_counter #(.W(DUR_W)) u_dur (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (state_q == S_LOAD && !bus.start),
    .dec_i  (step),
    .val_i  (w_dur),
    .zero_o (note_end)
  );
  // next state: start overrides everything, otherwise fetch/load/play/done sequencing
  always_comb begin
    state_d = state_q;
    song_d = song_q;
    idx_d = idx_q;
    note_d = note_q;
    last_d = last_q;
    if (bus.start) begin
      song_d = bus.select;
      idx_d = '0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          note_d = w_note;
          last_d = w_last;
          state_d = w_dur == '0 ? S_DONE : S_PLAY;
        end
        S_PLAY: if (note_end) begin
          state_d = (last_q || idx_q == '1) ? S_DONE : S_FETCH;
          idx_d = (last_q || idx_q == '1) ? idx_q : idx_q + 1'b1;
        end
        S_DONE: begin
          state_d = LOOP ? S_FETCH : S_IDLE;
          idx_d = LOOP ? '0 : idx_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // state and song registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      song_q <= '0;
      idx_q <= '0;
      note_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q <= song_d;
      idx_q <= idx_d;
      note_q <= note_d;
      last_q <= last_d;
    end
  end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays the currently selected song by walking its words in song memory, one note at a time. Each note is held for its encoded duration in tempo ticks, then the next word is fetched. The block sits between the song-selection state machine (whose `select`/`start` it consumes) and the song ROM/tone generator. It owns the memory address, the note currently sounding, and end-of-song signalling.

## Interface
Parameters:
- `IDX_W`, 6: bits of note index per song; 2^IDX_W words per song.
- `NOTE_W`, 4: note code width; code 0 = rest.
- `DUR_W`, 4: duration field width, in ticks.
- `LOOP`, 1: 1 = restart the song after it ends; 0 = go idle.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `select`  in  2  song number from the selector; sampled only when `start`=1.
- `start`  in  1  one-cycle pulse: begin the song on `select` from note 0.
- `enable`  in  1  1 = play, 0 = pause (freeze).
- `tick`  in  1  one-cycle tempo strobe.
- `mem_addr`  out  2+IDX_W  word address = {song, index}.
- `mem_rdata`  in  1+NOTE_W+DUR_W  word = {last, note, dur}, with MSB = `last`.
- `note_out`  out  NOTE_W  note being played.
- `note_valid`  out  1  1 while a note is sounding.
- `song_done`  out  1  one-cycle pulse at song end.

## Operation
- Memory is a synchronous-read memory: it samples `mem_addr` at a clock edge and `mem_rdata` is valid in the following cycle.
- `mem_addr` is a combinational function of the registered `song` and `index` only.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE: waits for `start`.
- FETCH: presents the address for one cycle, then goes to LOAD.
- LOAD: latches `note`, `dur` and `last` from `mem_rdata`.
  - If `dur`=0, the word is an end marker: go to DONE.
  - Otherwise: `cnt`←`dur`, go to PLAY.
- PLAY: on each cycle with `tick`=1 and `enable`=1, `cnt` decrements. When `cnt`=1 and such a tick occurs, the note ends:
  - if `last`=1, or `index`=2^IDX_W−1: go to DONE;
  - else `index`←`index`+1 and go to FETCH.
- DONE: assert `song_done` for one cycle, then:
  - if `LOOP`=1: `index`←0, go to FETCH;
  - else go to IDLE.
- `note_out` holds the latched note in every state. `note_valid` = (state==PLAY) & `enable` & (`note`≠0).
- `start` has top priority in every state. On `start`: `song`←`select`, `index`←0, go to FETCH. This aborts any note in progress and suppresses `song_done`.
- Pause (`enable`=0):
  - in PLAY, freezes `cnt` and mutes `note_valid`;
  - FETCH and LOAD still complete, so the pipeline lands in PLAY and waits there.
- `tick` is ignored outside PLAY. A tick in the same cycle as LOAD does not count toward the new note.
- `index` never wraps silently; reaching the last slot ends the song.

## Timing
- Reset values: state=IDLE, `song`=0, `index`=0, `cnt`=0, `note`=0, `last`=0.
  - Resulting outputs: `mem_addr`=0, `note_out`=0, `note_valid`=0, `song_done`=0.
- `start` sampled at edge k:
  - FETCH during cycle k..k+1;
  - LOAD after edge k+1;
  - PLAY, and `note_valid`=1 for a non-rest note, after edge k+2.
- Note length: exactly `dur` qualifying ticks.
- Inter-note gap: 2 cycles (FETCH, LOAD) with `note_valid`=0.
- `song_done` is high exactly one cycle, in DONE.
  - With LOOP=1, FETCH follows directly and note 0 sounds 3 cycles after DONE is entered.
- Reset is asynchronous; deassertion must be synchronous to `clk` (handled externally).

## Structure
- `note_seq_pkg` holds:
  - word-field widths and offsets (LAST_BIT, NOTE_LSB, DUR_LSB);
  - the state enum encoding;
  - the constant NOTE_REST=0.
- One sub-module, `duration_counter`: a loadable down-counter (load, dec, zero flag, width DUR_W).
- Everything else stays in `note_sequencer`.

## Test plan
- Basic playback: song 1 = {(n=5,d=2),(n=7,d=1,last)}; start with `select`=1, tick every 4 cycles.
  - Required: `mem_addr` 0x40 then 0x41; `note_out` 5 for 2 ticks, then 7 for 1 tick; one `song_done` pulse; return to IDLE (LOOP=0).
- End marker: word 0 with `dur`=0 → DONE at cycle k+2; `note_valid` never asserted.
- Pause: deassert `enable` mid-note for 10 cycles with ticks present.
  - Required: `cnt` unchanged and `note_valid`=0; after resume, the note completes its remaining ticks.
- Restart mid-note: `start` with `select`=2 while song 0 is in PLAY.
  - Required: next `mem_addr`=0x80, no `song_done`, new note 0 sounds after 2 cycles.
- Index limit and loop: a 64-word song with no `last` bit, LOOP=1.
  - Required: `song_done` after word 63, then `mem_addr` returns to {song,0}.
- Async reset: assert `reset_n`=0 mid-PLAY, between clock edges.
  - Required: all outputs go to their reset values immediately; the block stays in IDLE until `start`.
